rv_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the RV64I pipeline. It replaces the single PC register and IF|ID latch.
//  - Owns the fetch PC and issues in-order requests to instruction memory (valid/ready).
//  - Buffers up to DEPTH fetched instructions with their PCs and presents them to decode (valid/ready).
//  - On a redirect (branch/jump) it flushes all buffered work and discards stale in-flight responses.

---
 rtl/rv_fetch_queue_if.sv | 33 +++
 rtl/rv_fetch_queue.sv | 102 ++++++++++
 tb/tb_rv_fetch_queue.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_fetch_queue_if.sv
// Fetch-queue handshake bundle: instruction-memory request/response, redirect and decode ports.
// The master side is the fetch queue; the slave side is the memory/pipeline environment.
interface rv_fetch_queue_if #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            dec_valid;
   logic            dec_ready;
   logic [XLEN-1:0] dec_pc;
   logic [31:0]     dec_instr;
   logic [CntW-1:0] occupancy;

   modport master (
      output imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, occupancy,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
             dec_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, occupancy,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
             dec_ready
   );
endinterface

// File: rtl/rv_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, allocates a queue entry per request, fills
// entries in response order, presents the head to decode and flushes on redirect.
module rv_fetch_queue #(
   parameter int unsigned    XLEN     = 64,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic             clk,
   input logic             rst,
   rv_fetch_queue_if.master bus
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [CntW-1:0] cnt_t;

   logic [XLEN-1:0]  fetch_pc_q;
   ptr_t             head_q, fill_q, tail_q;
   cnt_t             occ_q;   // allocated entries
   cnt_t             pend_q;  // allocated but not yet filled
   cnt_t             drop_q;  // stale responses still owed by memory
   logic [DEPTH-1:0] filled_q, filled_d;
   logic [XLEN-1:0]  pc_mem_q    [DEPTH];
   logic [31:0]      instr_mem_q [DEPTH];

   logic credit_ok;
   logic req_fire;
   logic deq_fire;
   logic rsp_drop;
   logic rsp_fill;

   // Stale responses still hold credit, so a live response always finds a slot.
   assign credit_ok = ({1'b0, occ_q} + {1'b0, drop_q}) < (CntW + 1)'(DEPTH);

   assign bus.imem_req_valid = rst && credit_ok && !bus.redirect_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

   assign bus.dec_valid = filled_q[head_q];
   assign bus.dec_pc    = pc_mem_q[head_q];
   assign bus.dec_instr = instr_mem_q[head_q];
   assign bus.occupancy = occ_q;
   assign deq_fire      = bus.dec_valid && bus.dec_ready && !bus.redirect_valid;

   assign rsp_drop = bus.imem_rsp_valid && (drop_q != '0);
   assign rsp_fill = bus.imem_rsp_valid && (drop_q == '0);

   always_comb begin
      filled_d = filled_q;
      if (bus.redirect_valid) begin
         filled_d = '0;
      end else begin
         if (rsp_fill) filled_d[fill_q] = 1'b1;
         // Clear on dequeue so a drained queue never sees an old filled flag at the head.
         if (deq_fire) filled_d[head_q] = 1'b0;
         if (req_fire) filled_d[tail_q] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         head_q     <= '0;
         fill_q     <= '0;
         tail_q     <= '0;
         occ_q      <= '0;
         pend_q     <= '0;
         drop_q     <= '0;
         filled_q   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (bus.redirect_valid) begin
         fetch_pc_q <= {bus.redirect_pc[XLEN-1:2], 2'b00};
         head_q     <= '0;
         fill_q     <= '0;
         tail_q     <= '0;
         occ_q      <= '0;
         pend_q     <= '0;
         // Everything still owed by memory becomes stale; this cycle's response is one of them.
         drop_q     <= drop_q + pend_q - cnt_t'(bus.imem_rsp_valid);
         filled_q   <= filled_d;
      end else begin
         filled_q <= filled_d;
         if (req_fire) begin
            pc_mem_q[tail_q] <= fetch_pc_q;
            tail_q           <= tail_q + ptr_t'(1);
            fetch_pc_q       <= fetch_pc_q + XLEN'(4);
         end
         if (rsp_fill) begin
            instr_mem_q[fill_q] <= bus.imem_rsp_data;
            fill_q              <= fill_q + ptr_t'(1);
         end
         if (rsp_drop) drop_q <= drop_q - cnt_t'(1);
         if (deq_fire) head_q <= head_q + ptr_t'(1);
         occ_q  <= occ_q + cnt_t'(req_fire) - cnt_t'(deq_fire);
         pend_q <= pend_q + cnt_t'(req_fire) - cnt_t'(rsp_fill);
      end
   end
endmodule

// File: tb/tb_rv_fetch_queue.sv
// Bench for rv_fetch_queue: directed scenarios plus random traffic, checked every cycle against a
// queue-based reference model driven by a fixed-latency in-order memory model.
module tb_rv_fetch_queue;
   localparam int          XLEN     = 64;
   localparam int          DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h0;

   typedef struct {
      logic [63:0] pc;
      logic        filled;
      logic [31:0] instr;
   } ent_t;

   typedef struct {
      int unsigned due;
      logic [31:0] data;
   } mrsp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   rv_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) f ();

   rv_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(f.master)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;
   int unsigned lat    = 1;

   ent_t        mq[$];     // expected queue contents, head first
   int          mdrop = 0; // expected stale responses owed
   logic [63:0] mpc   = RESET_PC;
   mrsp_t       mem_q[$];  // memory in-flight responses

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic redir, input logic [63:0] rpc, input logic dready,
                        input logic mready);
      logic        rsp_v;
      logic [31:0] rsp_d;
      logic        exp_rv, exp_dv, req_fire, deq;
      int          unf;
      rsp_v = 1'b0;
      rsp_d = '0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         rsp_v = 1'b1;
         rsp_d = mem_q[0].data;
         mem_q.delete(0);
      end
      f.redirect_valid = redir;
      f.redirect_pc    = rpc;
      f.dec_ready      = dready;
      f.imem_req_ready = mready;
      f.imem_rsp_valid = rsp_v;
      f.imem_rsp_data  = rsp_d;
      @(negedge clk);
      exp_rv = (mq.size() + mdrop < DEPTH) && !redir;
      exp_dv = (mq.size() > 0) && mq[0].filled;
      check("req_valid", 64'(f.imem_req_valid), 64'(exp_rv));
      check("dec_valid", 64'(f.dec_valid), 64'(exp_dv));
      check("occupancy", 64'(f.occupancy), 64'(mq.size()));
      if (exp_rv) check("req_addr", f.imem_req_addr, mpc);
      if (exp_dv) begin
         check("dec_pc", f.dec_pc, mq[0].pc);
         check("dec_instr", 64'(f.dec_instr), 64'(mq[0].instr));
      end
      req_fire = exp_rv && mready;
      deq      = exp_dv && dready && !redir;
      if (req_fire) mem_q.push_back('{due: cyc + lat, data: instr_of(mpc)});
      if (redir) begin
         unf = 0;
         foreach (mq[i]) if (!mq[i].filled) unf++;
         mdrop = mdrop + unf - int'(rsp_v);
         mq.delete();
         mpc = rpc & ~64'h3;
      end else begin
         if (rsp_v) begin
            if (mdrop > 0) mdrop--;
            else begin
               for (int i = 0; i < mq.size(); i++) begin
                  if (!mq[i].filled) begin
                     mq[i].filled = 1'b1;
                     mq[i].instr  = rsp_d;
                     break;
                  end
               end
            end
         end
         if (deq) mq.delete(0);
         if (req_fire) begin
            mq.push_back('{pc: mpc, filled: 1'b0, instr: 32'h0});
            mpc = mpc + 64'd4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n, input logic dready, input logic mready);
      for (int i = 0; i < n; i++) cycle(1'b0, 64'h0, dready, mready);
   endtask

   task automatic do_reset();
      rst              = 1'b0;
      f.redirect_valid = 1'b0;
      f.redirect_pc    = '0;
      f.dec_ready      = 1'b0;
      f.imem_req_ready = 1'b0;
      f.imem_rsp_valid = 1'b0;
      f.imem_rsp_data  = '0;
      #1;
      check("rst_req_valid", 64'(f.imem_req_valid), 64'h0);
      check("rst_dec_valid", 64'(f.dec_valid), 64'h0);
      check("rst_occupancy", 64'(f.occupancy), 64'h0);
      check("rst_dec_pc", f.dec_pc, 64'h0);
      check("rst_dec_instr", 64'(f.dec_instr), 64'h0);
      mq.delete();
      mem_q.delete();
      mdrop = 0;
      mpc   = RESET_PC;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc++;
   endtask

   initial begin
      // Streaming with a 1-cycle memory: 0,4,8,12... back to back.
      do_reset();
      lat = 1;
      run(8, 1'b1, 1'b1);

      // Decode stalled: queue fills to DEPTH and requests stop.
      do_reset();
      run(8, 1'b0, 1'b1);
      check("full_occ", 64'(f.occupancy), 64'(DEPTH));
      check("full_req_valid", 64'(f.imem_req_valid), 64'h0);
      check("full_dec_pc", f.dec_pc, RESET_PC);

      // Slow memory: redirect with two requests outstanding, then back-to-back redirects.
      do_reset();
      lat = 3;
      run(2, 1'b1, 1'b1);
      cycle(1'b1, 64'h100, 1'b1, 1'b1);
      run(10, 1'b1, 1'b1);
      run(2, 1'b1, 1'b1);
      cycle(1'b1, 64'h400, 1'b1, 1'b1);
      cycle(1'b1, 64'h800, 1'b1, 1'b1);
      run(10, 1'b1, 1'b1);

      // Unaligned redirect target.
      cycle(1'b1, 64'h203, 1'b1, 1'b1);
      check("redir_align", f.imem_req_addr, 64'h200);
      run(6, 1'b1, 1'b1);

      // Redirect coinciding with a response and a dequeue.
      do_reset();
      lat = 1;
      run(4, 1'b1, 1'b1);
      cycle(1'b1, 64'h1000, 1'b1, 1'b1);
      check("redir_occ", 64'(f.occupancy), 64'h0);
      run(6, 1'b1, 1'b1);

      // Reset with entries queued, then 3*DEPTH sequential fetches through the wrap.
      do_reset();
      run(2, 1'b0, 1'b1);
      do_reset();
      run(3 * DEPTH + 4, 1'b1, 1'b1);

      // Random traffic with occasional redirects.
      do_reset();
      lat = 2;
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 19) == 0, {$urandom, $urandom},
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
